// File: rtl/status_led_pkg.sv
// Shared definitions for the status LED block: o_state encoding, FSM state type,
// and the blink half-period calculation. Test tops import this to decode o_state.
package status_led_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_PASS = PASS,
        ST_FAIL = FAIL
    } state_t;

    // Clock cycles per blink half-period, never less than one.
    function automatic int calc_half(input int clk_freq, input int blink_hz);
        int h;
        if (blink_hz <= 0) begin
            h = 1;
        end else begin
            h = clk_freq / (2 * blink_hz);
        end
        if (h < 1) begin
            h = 1;
        end
        return h;
    endfunction

endpackage

// File: rtl/blink_div.sv
// Blink phase generator: counts 0..HALF-1 and toggles the phase on every wrap.
// A restart clears the count and forces the phase on, so a new blink starts lit.
module blink_div #(
    parameter int HALF = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_phase
);

    localparam int HALF_C = (HALF < 1) ? 1 : HALF;
    localparam int CW     = (HALF_C > 1) ? $clog2(HALF_C) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_C - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            o_phase <= 1'b0;
        end else if (i_restart) begin
            cnt     <= '0;
            o_phase <= 1'b1;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            o_phase <= ~o_phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/status_led.sv
// Test-fixture status indicator: tracks idle/run/pass/fail from the fixture flags
// and drives one PWM-dimmed RGB channel (blue blink, steady green, red blink).
module status_led
    import status_led_pkg::*;
#(
    parameter int CLK_FREQ = 48_000_000,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 4,
    parameter int DUTY     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_running,
    input  logic       i_passed,
    output logic       o_led_r,
    output logic       o_led_g,
    output logic       o_led_b,
    output logic [1:0] o_state
);

    localparam int HALF = calc_half(CLK_FREQ, BLINK_HZ);
    localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);

    logic                running;
    logic                passed;
    state_t              state;
    state_t              state_next;
    logic                restart;
    logic                phase;
    logic                pwm_on;
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            running <= 1'b0;
            passed  <= 1'b0;
        end else begin
            running <= i_running;
            passed  <= i_passed;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // passed only matters on the sample where running drops while in RUN.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:          if (running) state_next = ST_RUN;
            ST_RUN:           if (!running) state_next = passed ? ST_PASS : ST_FAIL;
            ST_PASS, ST_FAIL: if (running) state_next = ST_RUN;
            default:          state_next = ST_IDLE;
        endcase
        restart = (state_next != state) &&
                  ((state_next == ST_RUN) || (state_next == ST_FAIL));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Extra compare bit lets DUTY = 2^PWM_BITS mean permanently on.
    assign pwm_on = ({1'b0, pwm_cnt} < DUTY_W);

    blink_div #(
        .HALF(HALF)
    ) u_blink_div (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_restart(restart),
        .o_phase  (phase)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_led_r <= 1'b0;
            o_led_g <= 1'b0;
            o_led_b <= 1'b0;
        end else begin
            o_led_r <= 1'b0;
            o_led_g <= 1'b0;
            o_led_b <= 1'b0;
            case (state)
                ST_RUN:  o_led_b <= phase & pwm_on;
                ST_PASS: o_led_g <= pwm_on;
                ST_FAIL: o_led_r <= phase & pwm_on;
                default: ;
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_status_led.sv
// Randomized bench for status_led at CLK_FREQ=16, BLINK_HZ=2, PWM_BITS=2 with
// three instances (DUTY 4, 1, 0) compared against an arithmetic reference model.
module tb_status_led;
    import status_led_pkg::*;

    localparam int HALF     = 4;
    localparam int PWM_SPAN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       running;
    logic       passed;
    logic [2:0] led_r;
    logic [2:0] led_g;
    logic [2:0] led_b;
    logic [1:0] st [3];

    int checks = 0;
    int errors = 0;

    int duty_tab [3] = '{4, 1, 0};

    // Reference model: state after each edge, edge count since reset, blink entry edge.
    int m_k;
    int m_state;
    int m_entry;
    bit m_run_q;
    bit m_pass_q;
    bit exp_r [3];
    bit exp_g [3];
    bit exp_b [3];

    always #5 clk = ~clk;

    status_led #(.CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .DUTY(4)) dut_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
        .o_led_r(led_r[0]), .o_led_g(led_g[0]), .o_led_b(led_b[0]), .o_state(st[0]));

    status_led #(.CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .DUTY(1)) dut_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
        .o_led_r(led_r[1]), .o_led_g(led_g[1]), .o_led_b(led_b[1]), .o_state(st[1]));

    status_led #(.CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .DUTY(0)) dut_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
        .o_led_r(led_r[2]), .o_led_g(led_g[2]), .o_led_b(led_b[2]), .o_state(st[2]));

    // Blink phase is on for the first HALF edges after entry, then alternates;
    // the PWM count simply follows the edge count since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k      = 0;
            m_state  = 0;
            m_entry  = 0;
            m_run_q  = 1'b0;
            m_pass_q = 1'b0;
            for (int d = 0; d < 3; d++) begin
                exp_r[d] = 1'b0;
                exp_g[d] = 1'b0;
                exp_b[d] = 1'b0;
            end
        end else begin
            int  nxt;
            bit  phase_on;
            bit  pwm_on;
            m_k++;
            phase_on = (((m_k - 1 - m_entry) / HALF) % 2) == 0;
            for (int d = 0; d < 3; d++) begin
                pwm_on   = ((m_k - 1) % PWM_SPAN) < duty_tab[d];
                exp_r[d] = (m_state == 3) && phase_on && pwm_on;
                exp_g[d] = (m_state == 2) && pwm_on;
                exp_b[d] = (m_state == 1) && phase_on && pwm_on;
            end
            nxt = m_state;
            if (m_run_q) begin
                nxt = 1;
            end else if (m_state == 1) begin
                nxt = m_pass_q ? 2 : 3;
            end
            if ((nxt != m_state) && ((nxt == 1) || (nxt == 3))) begin
                m_entry = m_k;
            end
            m_state  = nxt;
            m_run_q  = running;
            m_pass_q = passed;
        end
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        running = 1'b0;
        passed  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({led_r, led_g, led_b} !== 9'b0) begin
                errors++;
                $display("[TB] FAIL reset_leds: got %b want 0", {led_r, led_g, led_b});
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (st[d] !== IDLE) begin
                    errors++;
                    $display("[TB] FAIL reset_state[%0d]: got %0d want 0", d, st[d]);
                end
            end
            running = 1'($urandom_range(0, 1));
            passed  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_run_blink();
        @(negedge clk);
        running = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (st[0] !== IDLE || {led_r, led_g, led_b} !== 9'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_release: state %0d leds %b", st[0], {led_r, led_g, led_b});
            end
            passed = 1'($urandom_range(0, 1));
        end
        running = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            logic [1:0] want_st;
            logic       want_b;
            @(negedge clk);
            want_st = (c >= 2) ? RUN : IDLE;
            want_b  = (c >= 3) && ((((c - 3) / HALF) % 2) == 0);
            checks++;
            if (st[0] !== want_st) begin
                errors++;
                $display("[TB] FAIL run_state c=%0d: got %0d want %0d", c, st[0], want_st);
            end
            checks++;
            if (led_b[0] !== want_b || led_r[0] !== 1'b0 || led_g[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL run_blink c=%0d: rgb %b%b%b want 00%b", c, led_r[0], led_g[0], led_b[0], want_b);
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({led_r[d], led_g[d], led_b[d]} !== {exp_r[d], exp_g[d], exp_b[d]} || st[d] !== 2'(m_state)) begin
                    errors++;
                    $display("[TB] FAIL run_model[%0d]: rgb %b%b%b st %0d want %b%b%b st %0d", d,
                             led_r[d], led_g[d], led_b[d], st[d], exp_r[d], exp_g[d], exp_b[d], m_state);
                end
            end
            passed = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_pass();
        int g1_count = 0;
        running = 1'b0;
        passed  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if (st[0] !== ((c >= 2) ? PASS : RUN)) begin
                errors++;
                $display("[TB] FAIL pass_state c=%0d: got %0d", c, st[0]);
            end
            if (c >= 3) begin
                checks++;
                if (led_g[0] !== 1'b1 || led_b[0] !== 1'b0 || led_r[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pass_green c=%0d: rgb %b%b%b want 010", c, led_r[0], led_g[0], led_b[0]);
                end
                checks++;
                if (led_g[2] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pass_duty0 c=%0d: green %b want 0", c, led_g[2]);
                end
                if (c <= 10 && led_g[1] === 1'b1) g1_count++;
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({led_r[d], led_g[d], led_b[d]} !== {exp_r[d], exp_g[d], exp_b[d]} || st[d] !== 2'(m_state)) begin
                    errors++;
                    $display("[TB] FAIL pass_model[%0d]: rgb %b%b%b st %0d want %b%b%b st %0d", d,
                             led_r[d], led_g[d], led_b[d], st[d], exp_r[d], exp_g[d], exp_b[d], m_state);
                end
            end
            passed = 1'($urandom_range(0, 1));
        end
        checks++;
        if (g1_count != 2) begin
            errors++;
            $display("[TB] FAIL pass_duty1: green high %0d of 8 cycles, want 2", g1_count);
        end
    endtask

    task automatic test_fail();
        int n = $urandom_range(3, 10);
        running = 1'b1;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (st[0] !== 2'(m_state)) begin
                errors++;
                $display("[TB] FAIL rerun_from_pass: state %0d want %0d", st[0], m_state);
            end
        end
        running = 1'b0;
        passed  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            logic want_r;
            @(negedge clk);
            want_r = (c >= 3) && ((((c - 3) / HALF) % 2) == 0);
            checks++;
            if (st[0] !== ((c >= 2) ? FAIL : RUN)) begin
                errors++;
                $display("[TB] FAIL fail_state c=%0d: got %0d", c, st[0]);
            end
            if (c >= 3) begin
                checks++;
                if (led_r[0] !== want_r || led_g[0] !== 1'b0 || led_b[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fail_blink c=%0d: rgb %b%b%b want %b00", c, led_r[0], led_g[0], led_b[0], want_r);
                end
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({led_r[d], led_g[d], led_b[d]} !== {exp_r[d], exp_g[d], exp_b[d]} || st[d] !== 2'(m_state)) begin
                    errors++;
                    $display("[TB] FAIL fail_model[%0d]: rgb %b%b%b st %0d want %b%b%b st %0d", d,
                             led_r[d], led_g[d], led_b[d], st[d], exp_r[d], exp_g[d], exp_b[d], m_state);
                end
            end
            passed = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_rerun_from_fail();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        running = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (st[0] !== ((c >= 2) ? RUN : FAIL)) begin
                errors++;
                $display("[TB] FAIL rerun_state c=%0d: got %0d", c, st[0]);
            end
            if (c == 3) begin
                checks++;
                if (led_b[0] !== 1'b1 || led_r[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rerun_first_led: r %b b %b want r 0 b 1", led_r[0], led_b[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({led_r[d], led_g[d], led_b[d]} !== {exp_r[d], exp_g[d], exp_b[d]} || st[d] !== 2'(m_state)) begin
                    errors++;
                    $display("[TB] FAIL random_model[%0d] i=%0d: rgb %b%b%b st %0d want %b%b%b st %0d", d, i,
                             led_r[d], led_g[d], led_b[d], st[d], exp_r[d], exp_g[d], exp_b[d], m_state);
                end
                checks++;
                if ((32'(led_r[d]) + 32'(led_g[d]) + 32'(led_b[d])) > 1) begin
                    errors++;
                    $display("[TB] FAIL one_hot[%0d] i=%0d: rgb %b%b%b", d, i, led_r[d], led_g[d], led_b[d]);
                end
            end
            if ($urandom_range(0, 9) == 0) running = ~running;
            passed = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_async_reset();
        running = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (st[0] !== RUN) begin
            errors++;
            $display("[TB] FAIL pre_reset_state: got %0d want 1", st[0]);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== 9'b0 || st[0] !== IDLE || st[1] !== IDLE || st[2] !== IDLE) begin
            errors++;
            $display("[TB] FAIL async_reset: leds %b states %0d %0d %0d want all 0",
                     {led_r, led_g, led_b}, st[0], st[1], st[2]);
        end
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (st[0] !== IDLE || {led_r, led_g, led_b} !== 9'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle i=%0d: state %0d leds %b", i, st[0], {led_r, led_g, led_b});
            end
            passed = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        running = 1'b0;
        passed  = 1'b0;
        test_reset();
        test_run_blink();
        test_pass();
        test_fail();
        test_rerun_from_fail();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
